// File: rtl/stage_c_fetch_data.sv
// Fetch-data stage: captures an operation/pointer from decode, reads the data cell
// when the operation needs it, forwards same-address write-back data, and hands off to execute.
module stage_c_fetch_data #(
  parameter int                     A_WIDTH   = 12,
  parameter int                     D_WIDTH   = 8,
  parameter int                     OP_WIDTH  = 8,
  parameter logic [OP_WIDTH-1:0]    READ_MASK = 8'b0011_1100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_WIDTH-1:0] operation_in,
  input  logic [A_WIDTH-1:0]  dp_in,
  input  logic                drdy_in,
  output logic                ack,
  output logic                dce,
  output logic [A_WIDTH-1:0]  da,
  input  logic [D_WIDTH-1:0]  dd,
  input  logic                wb_we,
  input  logic [A_WIDTH-1:0]  wb_addr,
  input  logic [D_WIDTH-1:0]  wb_data,
  output logic [OP_WIDTH-1:0] operation,
  output logic [A_WIDTH-1:0]  dp,
  output logic [D_WIDTH-1:0]  data,
  output logic                drdy,
  input  logic                ack_in
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, HOLD} state_t;

  state_t             state;
  logic               fwd_valid;
  logic [D_WIDTH-1:0] fwd_data;
  logic               is_read;
  logic               wb_hit;

  assign is_read = |(operation_in & READ_MASK);
  // dp holds the captured pointer for the whole item, so it doubles as the compare address
  assign wb_hit  = wb_we && (wb_addr == dp);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ack       <= 1'b0;
      dce       <= 1'b0;
      da        <= '0;
      drdy      <= 1'b0;
      operation <= '0;
      dp        <= '0;
      data      <= '0;
      fwd_valid <= 1'b0;
      fwd_data  <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (drdy_in) begin
            operation <= operation_in;
            dp        <= dp_in;
            ack       <= 1'b1;
            fwd_valid <= 1'b0;
            if (is_read) begin
              dce   <= 1'b1;
              da    <= dp_in;
              state <= READ;
            end else begin
              data  <= '0;
              drdy  <= 1'b1;
              state <= HOLD;
            end
          end
        end
        READ: begin
          dce <= 1'b0;
          da  <= '0;
          if (wb_hit) begin
            fwd_valid <= 1'b1;
            fwd_data  <= wb_data;
          end
          state <= WAIT;
        end
        WAIT: begin
          // A write landing in this very cycle is newer than anything stored
          if (wb_hit)         data <= wb_data;
          else if (fwd_valid) data <= fwd_data;
          else                data <= dd;
          drdy  <= 1'b1;
          state <= HOLD;
        end
        HOLD: begin
          if (ack_in) begin
            drdy      <= 1'b0;
            fwd_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
